prince_sbox_fwd_masked: RTL and testbench

//  Two-share first-order threshold implementation of the forward PRINCE S-box with a streaming valid/ready interface.

---
 rtl/prince_pkg.sv | 32 +++
 rtl/prince_sbox_fwd_masked_if.sv | 36 +++
 rtl/prince_sbox_fwd_comp.sv | 54 +++++
 rtl/prince_sbox_fwd_masked.sv | 66 ++++++
 tb/tb_prince_sbox_fwd_masked.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/prince_pkg.sv
// Shared PRINCE S-box tables and share types for the masked S-box datapaths.
// Also provides the ANF helper used to build the threshold component functions.
package prince_pkg;

  typedef logic [3:0] nibble_t;

  typedef struct packed {
    nibble_t sh0;
    nibble_t sh1;
  } share2_t;

  localparam nibble_t PRINCE_SBOX [16] = '{
    4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
    4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
  };

  localparam nibble_t PRINCE_SBOX_INV [16] = '{
    4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
  };

  // Algebraic normal form coefficient of monomial `mono` in output bit `bit_idx`.
  function automatic logic anf_coef(input int unsigned bit_idx, input nibble_t mono);
    logic acc;
    acc = 1'b0;
    for (int unsigned x = 0; x < 16; x++) begin
      if ((nibble_t'(x) & ~mono) == '0) acc ^= PRINCE_SBOX[x[3:0]][bit_idx[1:0]];
    end
    return acc;
  endfunction

endpackage

// File: rtl/prince_sbox_fwd_masked_if.sv
// Streaming valid/ready bus for the two-share forward PRINCE S-box.
// The rnd signal exists only when PRINCE_SBOX_REMASK_EN is defined.
interface prince_sbox_fwd_masked_if;
  import prince_pkg::*;

  logic    in_valid;
  logic    in_ready;
  nibble_t in_sh0;
  nibble_t in_sh1;
`ifdef PRINCE_SBOX_REMASK_EN
  nibble_t rnd;
`endif
  logic    out_valid;
  logic    out_ready;
  nibble_t out_sh0;
  nibble_t out_sh1;

  modport master (
    output in_valid, in_sh0, in_sh1,
`ifdef PRINCE_SBOX_REMASK_EN
    output rnd,
`endif
    output out_ready,
    input  in_ready, out_valid, out_sh0, out_sh1
  );

  modport slave (
    input  in_valid, in_sh0, in_sh1,
`ifdef PRINCE_SBOX_REMASK_EN
    input  rnd,
`endif
    input  out_ready,
    output in_ready, out_valid, out_sh0, out_sh1
  );

endinterface

// File: rtl/prince_sbox_fwd_comp.sv
// Combinational non-complete component functions of the two-share forward PRINCE S-box.
// comp[{bit[1:0], share, q[1:0]}]: 8 per output bit, 4 per output share.
module prince_sbox_fwd_comp
  import prince_pkg::*;
(
  input  share2_t     x,
  output logic [31:0] comp
);

  // Components are indexed by even-parity share tuples (ia,ib,ic,id); any three
  // indices fix the fourth, so each cross term of a <=cubic monomial has one owner.
  // Unused variables take 0 except the lowest-order one, which restores parity.
  nibble_t     mono;
  nibble_t     sel;
  nibble_t     owner;
  logic        term;
  logic [1:0]  fill_pos;
  logic [4:0]  idx;

  always_comb begin
    comp     = '0;
    mono     = '0;
    sel      = '0;
    owner    = '0;
    term     = 1'b0;
    fill_pos = '0;
    idx      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned u = 0; u < 15; u++) begin
        mono = nibble_t'(u);
        if (anf_coef(i, mono)) begin
          for (int unsigned s = 0; s < 16; s++) begin
            sel = nibble_t'(s);
            if ((sel & ~mono) == '0) begin
              term = 1'b1;
              for (int unsigned p = 0; p < 4; p++) begin
                if (mono[p[1:0]]) term &= sel[p[1:0]] ? x.sh1[p[1:0]] : x.sh0[p[1:0]];
              end
              fill_pos = '0;
              for (int unsigned p = 4; p > 0; p--) begin
                if (!mono[2'(p - 1)]) fill_pos = 2'(p - 1);
              end
              owner           = sel;
              owner[fill_pos] = ^sel;
              idx             = {i[1:0], owner[3:1]};
              comp[idx]       = comp[idx] ^ term;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/prince_sbox_fwd_masked.sv
// Two-share first-order threshold forward PRINCE S-box, two-stage valid/ready pipeline.
// Optional output remasking with fresh randomness: define PRINCE_SBOX_REMASK_EN.
module prince_sbox_fwd_masked
  import prince_pkg::*;
#(
  parameter bit ZERO_ON_IDLE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  prince_sbox_fwd_masked_if.slave      bus
);

  logic        en;
  share2_t     in_sh;
  logic [31:0] comp;
  logic [31:0] comp_q;
  logic        v1;
  logic        out_valid_q;
  nibble_t     c0;
  nibble_t     c1;
  nibble_t     nxt0;
  nibble_t     nxt1;
  nibble_t     sh0_q;
  nibble_t     sh1_q;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign in_sh        = {bus.in_sh0, bus.in_sh1};

  prince_sbox_fwd_comp u_comp (
    .x    (in_sh),
    .comp (comp)
  );

  assign c0 = {^comp_q[27:24], ^comp_q[19:16], ^comp_q[11:8], ^comp_q[3:0]};
  assign c1 = {^comp_q[31:28], ^comp_q[23:20], ^comp_q[15:12], ^comp_q[7:4]};

`ifdef PRINCE_SBOX_REMASK_EN
  assign nxt0 = c0 ^ bus.rnd;
  assign nxt1 = c1 ^ bus.rnd;
`else
  assign nxt0 = c0;
  assign nxt1 = c1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      comp_q      <= '0;
      out_valid_q <= 1'b0;
      sh0_q       <= '0;
      sh1_q       <= '0;
    end else if (en) begin
      v1          <= bus.in_valid;
      comp_q      <= (bus.in_valid || !ZERO_ON_IDLE) ? comp : '0;
      out_valid_q <= v1;
      sh0_q       <= (v1 || !ZERO_ON_IDLE) ? nxt0 : '0;
      sh1_q       <= (v1 || !ZERO_ON_IDLE) ? nxt1 : '0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sh0   = sh0_q;
  assign bus.out_sh1   = sh1_q;

endmodule

// File: tb/tb_prince_sbox_fwd_masked.sv
// Directed self-checking bench for the two-share forward PRINCE S-box pipeline.
// Covers exhaustive masking, streaming, backpressure, mid-stream reset, idle clearing, remask.
module tb_prince_sbox_fwd_masked;
  import prince_pkg::*;

  localparam logic [3:0] EXP_S [16] = '{
    4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
    4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
  };

  logic clk = 1'b0;
  logic rst;
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [3:0] held0, held1;
  logic [3:0] unm;
  logic [3:0] xv;

  always #5 clk = ~clk;

  prince_sbox_fwd_masked_if bus ();

  prince_sbox_fwd_masked #(.ZERO_ON_IDLE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] m);
    bus.in_valid = v;
    bus.in_sh0   = x ^ m;
    bus.in_sh1   = m;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0);
    bus.out_ready = 1'b1;
`ifdef PRINCE_SBOX_REMASK_EN
    bus.rnd = 4'h0;
`endif
    #1;
    check("rst_out_valid", {3'b0, bus.out_valid}, 4'h0);
    check("rst_sh0", bus.out_sh0, 4'h0);
    check("rst_sh1", bus.out_sh1, 4'h0);
    check("rst_in_ready", {3'b0, bus.in_ready}, 4'h1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // exhaustive x/mask sweep, back-to-back
    for (int unsigned idx = 0; idx <= 256; idx++) begin
      if (idx < 256) drive(1'b1, idx[7:4], idx[3:0]);
      else drive(1'b0, 4'h0, 4'h0);
`ifdef PRINCE_SBOX_REMASK_EN
      bus.rnd = 4'($urandom_range(15, 0));
`endif
      step();
      if (idx == 0) begin
        check("exh_first_latency", {3'b0, bus.out_valid}, 4'h0);
      end else begin
        xv  = 4'((idx - 1) >> 4);
        unm = bus.out_sh0 ^ bus.out_sh1;
        check("exh_valid", {3'b0, bus.out_valid}, 4'h1);
        check("exh_value", unm, EXP_S[xv]);
        check("exh_inverse", PRINCE_SBOX_INV[unm], xv);
      end
    end
    step();
    check("exh_drain_valid", {3'b0, bus.out_valid}, 4'h0);
    check("exh_drain_sh0", bus.out_sh0, 4'h0);
    check("exh_drain_sh1", bus.out_sh1, 4'h0);

    // streaming x = 1,2,3,4
    drive(1'b1, 4'h1, 4'h5); step();
    check("str_lat", {3'b0, bus.out_valid}, 4'h0);
    drive(1'b1, 4'h2, 4'h9); step();
    check("str_v0", {3'b0, bus.out_valid}, 4'h1);
    check("str_d0", bus.out_sh0 ^ bus.out_sh1, 4'hF);
    drive(1'b1, 4'h3, 4'hC); step();
    check("str_v1", {3'b0, bus.out_valid}, 4'h1);
    check("str_d1", bus.out_sh0 ^ bus.out_sh1, 4'h3);
    drive(1'b1, 4'h4, 4'h3); step();
    check("str_v2", {3'b0, bus.out_valid}, 4'h1);
    check("str_d2", bus.out_sh0 ^ bus.out_sh1, 4'h2);
    drive(1'b0, 4'h0, 4'h0); step();
    check("str_v3", {3'b0, bus.out_valid}, 4'h1);
    check("str_d3", bus.out_sh0 ^ bus.out_sh1, 4'hA);
    step();
    check("str_end", {3'b0, bus.out_valid}, 4'h0);

    // backpressure with two items in flight
    drive(1'b1, 4'h5, 4'h6); step();
    drive(1'b1, 4'h6, 4'hA); step();
    drive(1'b1, 4'h7, 4'h1);
    bus.out_ready = 1'b0;
    #1;
    check("bp_in_ready", {3'b0, bus.in_ready}, 4'h0);
    check("bp_head", bus.out_sh0 ^ bus.out_sh1, 4'hC);
    held0 = bus.out_sh0;
    held1 = bus.out_sh1;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      check("bp_valid", {3'b0, bus.out_valid}, 4'h1);
      check("bp_in_ready_hold", {3'b0, bus.in_ready}, 4'h0);
      check("bp_sh0_stable", bus.out_sh0, held0);
      check("bp_sh1_stable", bus.out_sh1, held1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {3'b0, bus.in_ready}, 4'h1);
    step();
    drive(1'b0, 4'h0, 4'h0);
    check("bp_item2_valid", {3'b0, bus.out_valid}, 4'h1);
    check("bp_item2", bus.out_sh0 ^ bus.out_sh1, 4'h9);
    step();
    check("bp_item3_valid", {3'b0, bus.out_valid}, 4'h1);
    check("bp_item3", bus.out_sh0 ^ bus.out_sh1, 4'h1);
    step();
    check("bp_end", {3'b0, bus.out_valid}, 4'h0);

    // reset while both stages are occupied
    drive(1'b1, 4'h2, 4'h4); step();
    drive(1'b1, 4'h8, 4'hF); step();
    check("mr_pre_valid", {3'b0, bus.out_valid}, 4'h1);
    #1 rst = 1'b1;
    #1;
    check("mr_valid", {3'b0, bus.out_valid}, 4'h0);
    check("mr_sh0", bus.out_sh0, 4'h0);
    check("mr_sh1", bus.out_sh1, 4'h0);
    drive(1'b0, 4'h0, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mr_in_ready", {3'b0, bus.in_ready}, 4'h1);
    step();
    check("mr_no_leak", {3'b0, bus.out_valid}, 4'h0);

    // idle clearing after x = 2
    drive(1'b1, 4'h2, 4'h7); step();
    drive(1'b0, 4'h0, 4'h0); step();
    check("idle_item_valid", {3'b0, bus.out_valid}, 4'h1);
    check("idle_item", bus.out_sh0 ^ bus.out_sh1, 4'h3);
    step();
    check("idle_valid", {3'b0, bus.out_valid}, 4'h0);
    check("idle_sh0", bus.out_sh0, 4'h0);
    check("idle_sh1", bus.out_sh1, 4'h0);

`ifdef PRINCE_SBOX_REMASK_EN
    bus.rnd = 4'h0;
    drive(1'b1, 4'h7, 4'h0); step();
    drive(1'b0, 4'h0, 4'h0); step();
    check("rm_base", bus.out_sh0 ^ bus.out_sh1, 4'h1);
    held0 = bus.out_sh0;
    held1 = bus.out_sh1;
    bus.rnd = 4'hA;
    drive(1'b1, 4'h7, 4'h0); step();
    drive(1'b0, 4'h0, 4'h0); step();
    check("rm_value", bus.out_sh0 ^ bus.out_sh1, 4'h1);
    check("rm_sh0_delta", bus.out_sh0 ^ held0, 4'hA);
    check("rm_sh1_delta", bus.out_sh1 ^ held1, 4'hA);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
